// File: rtl/arbitro_decodificador_pkg.sv
// Shared types and widths for the two-requester SECDED decoder sequencer.
package decodificador_pkg;
  localparam int ANCHO_PALABRA  = 8;
  localparam int ANCHO_DATO     = 4;
  localparam int ANCHO_SINDROME = 4;

  typedef enum logic [1:0] {INACTIVO, ESPERAR, ENTREGAR} estado_arb_t;

  typedef struct packed {
    logic [ANCHO_DATO-1:0]     dato;
    logic                      error_simple;
    logic                      error_doble;
    logic [ANCHO_SINDROME-1:0] sindrome;
  } resultado_dec_t;
endpackage

// File: rtl/arbitro_decodificador_if.sv
// Requester, decoder, result and status signals of the decoder sequencer.
interface arbitro_decodificador_if #(parameter int CNT_W = 8) ();
  import decodificador_pkg::*;
  logic                      req0_valido, req0_listo;
  logic [ANCHO_PALABRA-1:0]  req0_palabra;
  logic                      req1_valido, req1_listo;
  logic [ANCHO_PALABRA-1:0]  req1_palabra;
  logic [ANCHO_PALABRA-1:0]  dec_palabra;
  logic [ANCHO_DATO-1:0]     dec_dato;
  logic                      dec_error_simple, dec_error_doble;
  logic [ANCHO_SINDROME-1:0] dec_sindrome;
  logic                      res_valido, res_listo, res_id;
  logic [ANCHO_DATO-1:0]     res_dato;
  logic                      res_error_simple, res_error_doble;
  logic [ANCHO_SINDROME-1:0] res_sindrome;
  logic [CNT_W-1:0]          cnt_simple, cnt_doble;
  logic                      limpiar_cnt;

  // slave: the sequencer itself
  modport slave (
    input  req0_valido, req0_palabra, req1_valido, req1_palabra,
    output req0_listo, req1_listo, dec_palabra,
    input  dec_dato, dec_error_simple, dec_error_doble, dec_sindrome,
    output res_valido, res_id, res_dato, res_error_simple, res_error_doble, res_sindrome,
    input  res_listo, limpiar_cnt,
    output cnt_simple, cnt_doble
  );

  // master: requesters, decoder and consumer around it
  modport master (
    output req0_valido, req0_palabra, req1_valido, req1_palabra,
    input  req0_listo, req1_listo, dec_palabra,
    output dec_dato, dec_error_simple, dec_error_doble, dec_sindrome,
    input  res_valido, res_id, res_dato, res_error_simple, res_error_doble, res_sindrome,
    output res_listo, limpiar_cnt,
    input  cnt_simple, cnt_doble
  );
endinterface

// File: rtl/arbitro_decodificador_rr2.sv
// Two-requester round-robin grant; pointer names the favoured requester on a tie.
module arbitro_rr2 (
  input  logic       reloj,
  input  logic       reset,
  input  logic [1:0] valid,
  input  logic       avanzar,
  output logic [1:0] grant
);
  logic ptr_q;

  always_comb begin
    grant = 2'b00;
    case (valid)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = ptr_q ? 2'b10 : 2'b01;
      default: grant = 2'b00;
    endcase
  end

  // after a grant the other requester gets priority
  always_ff @(posedge reloj) begin
    if (reset)                   ptr_q <= 1'b0;
    else if (avanzar && |grant)  ptr_q <= grant[0];
  end
endmodule

// File: rtl/arbitro_decodificador.sv
// Shares one SECDED decoder between two requesters: accept, wait LAT_DEC, return tagged result.
module arbitro_decodificador
  import decodificador_pkg::*;
#(
  parameter int LAT_DEC = 1,
  parameter int CNT_W   = 8
) (
  input  logic reloj,
  input  logic reset,
  arbitro_decodificador_if.slave bus
);
  localparam logic [3:0]       ESPERA_INI = 4'(LAT_DEC - 1);
  localparam logic [CNT_W-1:0] CNT_MAX    = '1;

  estado_arb_t              estado_q, estado_d;
  logic [1:0]               valid, grant;
  logic                     aceptar, capturar;
  logic [3:0]               espera_q;
  logic [ANCHO_PALABRA-1:0] palabra_q;
  logic                     id_q;
  resultado_dec_t           res_q, dec_in;
  logic [CNT_W-1:0]         cnt_s_q, cnt_d_q;

  assign valid = {bus.req1_valido, bus.req0_valido};

  arbitro_rr2 u_rr (
    .reloj   (reloj),
    .reset   (reset),
    .valid   (valid),
    .avanzar (aceptar),
    .grant   (grant)
  );

  assign aceptar  = (estado_q == INACTIVO) && |grant && !reset;
  assign capturar = (estado_q == ESPERAR) && (espera_q == 4'd0);

  // a double error masks any single-error indication
  always_comb begin
    dec_in.dato         = bus.dec_dato;
    dec_in.error_doble  = bus.dec_error_doble;
    dec_in.error_simple = bus.dec_error_simple & ~bus.dec_error_doble;
    dec_in.sindrome     = bus.dec_sindrome;
  end

  always_comb begin
    estado_d = estado_q;
    case (estado_q)
      INACTIVO: if (aceptar)       estado_d = ESPERAR;
      ESPERAR:  if (capturar)      estado_d = ENTREGAR;
      ENTREGAR: if (bus.res_listo) estado_d = INACTIVO;
      default:                     estado_d = INACTIVO;
    endcase
  end

  always_ff @(posedge reloj) begin
    if (reset) begin
      estado_q  <= INACTIVO;
      espera_q  <= '0;
      palabra_q <= '0;
      id_q      <= 1'b0;
      res_q     <= '0;
    end else begin
      estado_q <= estado_d;
      if (aceptar) begin
        palabra_q <= grant[1] ? bus.req1_palabra : bus.req0_palabra;
        id_q      <= grant[1];
        espera_q  <= ESPERA_INI;
      end else if (estado_q == ESPERAR && !capturar) begin
        espera_q <= espera_q - 4'd1;
      end
      if (capturar) res_q <= dec_in;
    end
  end

  always_ff @(posedge reloj) begin
    if (reset || bus.limpiar_cnt) begin
      cnt_s_q <= '0;
      cnt_d_q <= '0;
    end else if (capturar) begin
      if (dec_in.error_simple && cnt_s_q != CNT_MAX) cnt_s_q <= cnt_s_q + 1'b1;
      if (dec_in.error_doble  && cnt_d_q != CNT_MAX) cnt_d_q <= cnt_d_q + 1'b1;
    end
  end

  assign bus.req0_listo       = aceptar & grant[0];
  assign bus.req1_listo       = aceptar & grant[1];
  assign bus.dec_palabra      = palabra_q;
  assign bus.res_valido       = (estado_q == ENTREGAR);
  assign bus.res_id           = id_q;
  assign bus.res_dato         = res_q.dato;
  assign bus.res_error_simple = res_q.error_simple;
  assign bus.res_error_doble  = res_q.error_doble;
  assign bus.res_sindrome     = res_q.sindrome;
  assign bus.cnt_simple       = cnt_s_q;
  assign bus.cnt_doble        = cnt_d_q;
endmodule

// File: tb/tb_arbitro_decodificador.sv
// Bench: two sequencer instances (LAT_DEC=1/CNT_W=8, LAT_DEC=3/CNT_W=2) against a transaction model.
module tb_arbitro_decodificador;
  logic reloj, rst, sel;
  logic v0, v1, rl, clr;
  logic [7:0] p0, p1;
  int n_tests, n_fail;
  logic m_ptr;
  int m_cs, m_cd;

  arbitro_decodificador_if #(.CNT_W(8)) ifa ();
  arbitro_decodificador_if #(.CNT_W(2)) ifb ();

  arbitro_decodificador #(.LAT_DEC(1), .CNT_W(8)) dut_a (.reloj(reloj), .reset(rst), .bus(ifa.slave));
  arbitro_decodificador #(.LAT_DEC(3), .CNT_W(2)) dut_b (.reloj(reloj), .reset(rst), .bus(ifb.slave));

  initial reloj = 1'b0;
  always #5 reloj = ~reloj;

  // stimulus goes only to the selected instance
  assign ifa.req0_valido  = !sel & v0;  assign ifb.req0_valido  = sel & v0;
  assign ifa.req1_valido  = !sel & v1;  assign ifb.req1_valido  = sel & v1;
  assign ifa.req0_palabra = p0;         assign ifb.req0_palabra = p0;
  assign ifa.req1_palabra = p1;         assign ifb.req1_palabra = p1;
  assign ifa.res_listo    = !sel & rl;  assign ifb.res_listo    = sel & rl;
  assign ifa.limpiar_cnt  = !sel & clr; assign ifb.limpiar_cnt  = sel & clr;

  // decoder stub: dato=high nibble, sindrome=low nibble, low nibble 1/2/3 = single/double/both
  logic [7:0] pb0, pb1;
  always_ff @(posedge reloj) begin
    pb0 <= ifb.dec_palabra;
    pb1 <= pb0;
  end
  assign ifa.dec_dato         = ifa.dec_palabra[7:4];
  assign ifa.dec_sindrome     = ifa.dec_palabra[3:0];
  assign ifa.dec_error_simple = ifa.dec_palabra[3:0] == 4'd1 || ifa.dec_palabra[3:0] == 4'd3;
  assign ifa.dec_error_doble  = ifa.dec_palabra[3:0] == 4'd2 || ifa.dec_palabra[3:0] == 4'd3;
  assign ifb.dec_dato         = pb1[7:4];
  assign ifb.dec_sindrome     = pb1[3:0];
  assign ifb.dec_error_simple = pb1[3:0] == 4'd1 || pb1[3:0] == 4'd3;
  assign ifb.dec_error_doble  = pb1[3:0] == 4'd2 || pb1[3:0] == 4'd3;

  logic       o_l0, o_l1, o_rv, o_id, o_es, o_ed;
  logic [7:0] o_dp, o_cs, o_cd;
  logic [3:0] o_dato, o_sd;
  assign o_l0   = sel ? ifb.req0_listo       : ifa.req0_listo;
  assign o_l1   = sel ? ifb.req1_listo       : ifa.req1_listo;
  assign o_rv   = sel ? ifb.res_valido       : ifa.res_valido;
  assign o_id   = sel ? ifb.res_id           : ifa.res_id;
  assign o_es   = sel ? ifb.res_error_simple : ifa.res_error_simple;
  assign o_ed   = sel ? ifb.res_error_doble  : ifa.res_error_doble;
  assign o_dp   = sel ? ifb.dec_palabra      : ifa.dec_palabra;
  assign o_dato = sel ? ifb.res_dato         : ifa.res_dato;
  assign o_sd   = sel ? ifb.res_sindrome     : ifa.res_sindrome;
  assign o_cs   = sel ? {6'd0, ifb.cnt_simple} : ifa.cnt_simple;
  assign o_cd   = sel ? {6'd0, ifb.cnt_doble}  : ifa.cnt_doble;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s (dut %0d) got %0h expected %0h at %0t", tag, sel, got, exp, $time);
    end
  endtask

  task automatic chk_idle_outputs();
    chk("rst_listo", {o_l1, o_l0}, 0);
    chk("rst_rv", o_rv, 0);
    chk("rst_res", {o_id, o_dato, o_es, o_ed, o_sd}, 0);
    chk("rst_dec_palabra", o_dp, 0);
    chk("rst_cnt_simple", o_cs, 0);
    chk("rst_cnt_doble", o_cd, 0);
  endtask

  task automatic do_reset();
    v0 = 0; v1 = 0; rl = 0; clr = 0; p0 = 0; p1 = 0;
    rst = 1;
    repeat (2) @(negedge reloj);
    rst = 0;
    m_ptr = 0; m_cs = 0; m_cd = 0;
    chk_idle_outputs();
  endtask

  // one full transaction starting at a negedge with the DUT idle
  task automatic txn(input logic a0, input logic [7:0] w0, input logic a1, input logic [7:0] w1,
                     input int bp, input logic clr_cap);
    logic g, es, ed;
    logic [7:0] w;
    int lat, cmax;
    lat  = sel ? 3 : 1;
    cmax = sel ? 3 : 255;
    v0 = a0; p0 = w0; v1 = a1; p1 = w1;
    #1;
    g = (a0 && a1) ? m_ptr : a1;
    w = g ? w1 : w0;
    chk("grant_listo0", o_l0, a0 && !g);
    chk("grant_listo1", o_l1, g);
    m_ptr = !g;
    es = (w[3:0] == 4'd1);
    ed = (w[3:0] == 4'd2) || (w[3:0] == 4'd3);
    for (int j = 0; j < lat; j++) begin
      @(negedge reloj);
      if (j == 0) begin
        if (g) v1 = 0; else v0 = 0;
      end
      chk("wait_rv", o_rv, 0);
      chk("wait_listo", {o_l1, o_l0}, 0);
      chk("dec_palabra", o_dp, w);
      if (clr_cap && j == lat - 1) clr = 1;
    end
    @(negedge reloj);
    clr = 0;
    if (clr_cap) begin
      m_cs = 0; m_cd = 0;
    end else begin
      if (es && m_cs < cmax) m_cs++;
      if (ed && m_cd < cmax) m_cd++;
    end
    chk("res_valido", o_rv, 1);
    chk("res_id", o_id, g);
    chk("res_dato", o_dato, w[7:4]);
    chk("res_sindrome", o_sd, w[3:0]);
    chk("res_flags", {o_es, o_ed}, {es, ed});
    chk("cnt_simple", o_cs, m_cs);
    chk("cnt_doble", o_cd, m_cd);
    for (int k = 0; k < bp; k++) begin
      @(negedge reloj);
      chk("bp_rv", o_rv, 1);
      chk("bp_hold", {o_id, o_dato, o_es, o_ed, o_sd}, {g, w[7:4], es, ed, w[3:0]});
      chk("bp_listo", {o_l1, o_l0}, 0);
    end
    rl = 1;
    @(negedge reloj);
    rl = 0;
    chk("drop_rv", o_rv, 0);
    chk("post_cnt", {o_cs, o_cd}, {m_cs[7:0], m_cd[7:0]});
  endtask

  task automatic random_txns(input int n);
    logic a0, a1;
    for (int i = 0; i < n; i++) begin
      a0 = 1'($urandom_range(0, 1));
      a1 = 1'($urandom_range(0, 1));
      if (!a0 && !a1) a0 = 1;
      txn(a0, 8'($urandom), a1, 8'($urandom), $urandom_range(0, 3), $urandom_range(0, 7) == 0);
    end
  endtask

  initial begin
    n_tests = 0; n_fail = 0;
    sel = 0;
    do_reset();
    repeat (3) begin
      @(negedge reloj);
      chk_idle_outputs();
    end
    // single clean word
    txn(1, 8'hAA, 0, 8'h00, 0, 0);
    // continuous contention alternates owners
    repeat (4) txn(1, 8'h2C, 1, 8'hDD, 0, 0);
    // three single errors, then both flags raised
    txn(1, 8'h51, 0, 8'h00, 0, 0);
    txn(0, 8'h00, 1, 8'h61, 1, 0);
    txn(1, 8'h71, 1, 8'h81, 0, 0);
    chk("cnt_simple_three", o_cs, 3);
    txn(1, 8'h93, 0, 8'h00, 0, 0);
    chk("cnt_doble_one", o_cd, 1);
    // back-pressure for five cycles
    txn(1, 8'h3E, 1, 8'hB2, 5, 0);
    // clear coinciding with an increment
    txn(1, 8'hC1, 0, 8'h00, 0, 1);
    chk("clr_on_inc", {o_cs, o_cd}, 0);
    random_txns(30);

    sel = 1;
    do_reset();
    // saturation of the 2-bit counter
    for (int i = 0; i < 5; i++) txn(1, 8'h11 + 8'(i << 4), 1, 8'h41, 0, 0);
    chk("cnt_sat", o_cs, 3);
    txn(0, 8'h00, 1, 8'h0F, 0, 1);
    chk("clr_sat", o_cs, 0);
    random_txns(20);

    // reset while waiting on the decoder
    v0 = 1; p0 = 8'h4A; v1 = 0; #1;
    chk("mid_listo0", o_l0, 1);
    @(negedge reloj);
    v0 = 0;
    @(negedge reloj);
    chk("mid_waiting", o_rv, 0);
    rst = 1;
    @(negedge reloj);
    rst = 0;
    m_ptr = 0; m_cs = 0; m_cd = 0;
    chk_idle_outputs();
    repeat (4) begin
      @(negedge reloj);
      chk("mid_no_rv", o_rv, 0);
    end
    // pointer back at requester 0 after reset
    txn(1, 8'h5A, 1, 8'hA5, 0, 0);
    chk("mid_ptr_id", o_id, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
